// File: rtl/alu_seq.sv
// Multi-cycle ALU sequencer: issues a BYTES-wide operation to an external 8-bit combinational
// ALU one byte per cycle (LSB first), chaining carry/shift bits, and returns the result + flags.
module alu_seq #(
  parameter int unsigned BYTES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [2:0]           i_req_op,
  input  logic [8*BYTES-1:0]   i_req_a,
  input  logic [8*BYTES-1:0]   i_req_b,
  input  logic                 i_req_cin,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ready,
  output logic [8*BYTES-1:0]   o_resp_data,
  output logic                 o_resp_carry,
  output logic                 o_resp_zero,
  output logic                 o_resp_pari,
  output logic [2:0]           o_alu_cmd,
  output logic [7:0]           o_alu_in_a,
  output logic [7:0]           o_alu_in_b,
  output logic                 o_alu_sc_i,
  input  logic [7:0]           i_alu_rslt,
  input  logic                 i_alu_sc_o
);

  localparam int unsigned W  = 8 * BYTES;
  localparam int unsigned IW = $clog2(BYTES);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpXor = 3'b011;
  localparam logic [2:0] OpCmp = 3'b100;
  localparam logic [2:0] OpMov = 3'b101;
  localparam logic [2:0] OpRol = 3'b110;
  localparam logic [2:0] OpRev = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e          r_state;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic [W-1:0]    r_resp_data;
  logic            r_resp_carry;
  logic            r_resp_zero;
  logic            r_resp_pari;
  logic [2:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_cin;
  logic            r_c;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_res;

  logic [IW-1:0]   w_rev_idx;
  logic [7:0]      w_a_byte;
  logic [7:0]      w_a_rev;
  logic [7:0]      w_b_byte;
  logic            w_init;
  logic            w_sc;
  logic            w_last;
  logic            w_arith;
  logic [W-1:0]    w_res_full;
  logic [W-1:0]    w_data;

  assign w_rev_idx = IW'(BYTES - 1) - r_idx;
  assign w_a_byte  = r_a[8*r_idx +: 8];
  assign w_a_rev   = r_a[8*w_rev_idx +: 8];
  assign w_b_byte  = r_b[8*r_idx +: 8];
  assign w_last    = (r_idx == IW'(BYTES - 1));
  assign w_arith   = (r_op == OpAdd) || (r_op == OpSub) || (r_op == OpCmp) || (r_op == OpRol);
  // Subtraction is a + ~b + 1, so the chain starts with a forced carry.
  assign w_init    = ((r_op == OpAdd) || (r_op == OpRol)) ? r_cin :
                     ((r_op == OpSub) || (r_op == OpCmp));
  assign w_sc      = (r_idx == '0) ? w_init : r_c;

  always_comb begin
    o_alu_cmd  = OpMov;
    o_alu_in_a = 8'h00;
    o_alu_in_b = 8'h00;
    o_alu_sc_i = 1'b0;
    if (r_state == StExec) begin
      unique case (r_op)
        OpAdd: begin
          o_alu_cmd = 3'b000; o_alu_in_a = w_a_byte; o_alu_in_b = w_b_byte; o_alu_sc_i = w_sc;
        end
        OpSub, OpCmp: begin
          o_alu_cmd = 3'b000; o_alu_in_a = w_a_byte; o_alu_in_b = ~w_b_byte; o_alu_sc_i = w_sc;
        end
        OpAnd: begin
          o_alu_cmd = 3'b010; o_alu_in_a = w_a_byte; o_alu_in_b = w_b_byte;
        end
        OpXor: begin
          o_alu_cmd = 3'b011; o_alu_in_a = w_a_byte; o_alu_in_b = w_b_byte;
        end
        OpMov: begin
          o_alu_cmd = 3'b101; o_alu_in_a = w_a_byte; o_alu_in_b = w_b_byte;
        end
        OpRol: begin
          o_alu_cmd = 3'b110; o_alu_in_a = w_a_byte; o_alu_sc_i = w_sc;
        end
        OpRev: begin
          o_alu_cmd = 3'b111; o_alu_in_a = w_a_rev;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_res_full = r_res;
    w_res_full[8*r_idx +: 8] = i_alu_rslt;
    w_data = (r_op == OpCmp) ? {{(W-1){1'b0}}, i_alu_sc_o} : w_res_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_carry <= 1'b0;
      r_resp_zero  <= 1'b0;
      r_resp_pari  <= 1'b0;
      r_op         <= 3'b000;
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
      r_c          <= 1'b0;
      r_idx        <= '0;
      r_res        <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_req_valid && r_req_ready) begin
            r_op        <= i_req_op;
            r_a         <= i_req_a;
            r_b         <= i_req_b;
            r_cin       <= i_req_cin;
            r_idx       <= '0;
            r_res       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= StExec;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        StExec: begin
          r_res[8*r_idx +: 8] <= i_alu_rslt;
          r_c                 <= i_alu_sc_o;
          if (w_last) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_data;
            r_resp_carry <= w_arith & i_alu_sc_o;
            r_resp_zero  <= (w_data == '0);
            r_resp_pari  <= ^w_data;
            r_state      <= StDone;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        StDone: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_carry = r_resp_carry;
  assign o_resp_zero  = r_resp_zero;
  assign o_resp_pari  = r_resp_pari;

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle ALU sequencer: the initiator side of the 8-bit ALU command/result interface. Accepts one BYTES-wide operation per valid/ready request and issues it to the combinational 8-bit ALU one byte per cycle, least-significant byte first. It chains carry and shift bits between byte passes and returns the assembled result with carry, zero and parity flags on a valid/ready response port. It sits between the datapath control and the ALU and is the only driver of the ALU inputs.

## Interface
- BYTES, 2, operand/result width in bytes (2..8); W = 8*BYTES
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE, low while rst_n low
- req_op  in  3  operation code, see Operation
- req_a, req_b  in  W  operands
- req_cin  in  1  carry-in for ADD, shift-in bit for ROL
- resp_valid  out  1  result present
- resp_ready  in  1  consumer accepts result
- resp_data  out  W  result
- resp_carry, resp_zero, resp_pari  out  1  flags
- alu_cmd  out  3  ALU command
- alu_inA, alu_inB  out  8  ALU operands
- alu_sc_i  out  1  ALU shift/carry in
- alu_rslt  in  8  ALU result, combinational from the ALU outputs of the same cycle
- alu_sc_o  in  1  ALU shift/carry out

## Operation
- States: IDLE, EXEC, DONE. Byte index idx counts 0..BYTES-1 in EXEC.
- IDLE: req_valid&&req_ready latches op, A, B, cin; clears idx and the result register; goes to EXEC.
- EXEC, each cycle: drive the ALU for byte idx and capture alu_rslt into result byte idx. The carry register c gets alu_sc_o. idx==BYTES-1 -> DONE, else idx+1.
- DONE: resp_valid=1. resp_valid&&resp_ready -> IDLE.
- Per-op ALU drive, with a = A byte idx, b = B byte idx, sc = (idx==0 ? init : c):
  - 000 ADD: cmd 000, inA=a, inB=b, sc_i=sc, init=req_cin.
  - 001 SUB: cmd 000, inB=~b, sc_i=sc, init=1 (two's complement). Final carry 1 = no borrow.
  - 010 AND: cmd 010. 011 XOR: cmd 011. 101 MOV: cmd 101, result=B. sc_i=0 for all three.
  - 100 CMP: computed as SUB. resp_data = {0…, final carry}, i.e. 1 when A>=B unsigned, else 0.
  - 110 ROL: cmd 110, inA=a, inB=0, sc_i=sc, init=req_cin. Shifts W bits left by one, with cin into bit 0.
  - 111 REV: cmd 111, inA = A byte (BYTES-1-idx). Result is full W-bit bit reversal of A.
- resp_carry = final c for ADD/SUB/CMP/ROL, 0 for other ops.
- resp_zero = (resp_data==0). resp_pari = ^resp_data.
- Flags are computed inside the block from captured alu_rslt bytes. The ALU zero/pari outputs are not used.
- ALU idle drive (IDLE, DONE): cmd 101, inA=inB=0, sc_i=0.

## Timing
- Reset (rst_n low, asynchronous) forces the following, taking effect immediately and not waiting for a clock edge:
  - state to IDLE
  - req_ready=0, resp_valid=0
  - resp_data=0 and all flags=0
  - c=0, idx=0
  - ALU idle drive
- Any in-flight operation is discarded.
- First edge after rst_n rises: req_ready=1.
- Acceptance at edge E0 -> EXEC cycles E0..E0+BYTES-1 -> resp_valid high after edge E0+BYTES. Latency is BYTES+1 cycles, request to response.
- One operation in flight; req_ready=0 from acceptance until the response handshake edge. No request is accepted on the response handshake edge; the next acceptance is possible one cycle later.
- resp_data and flags are stable while resp_valid&&!resp_ready. They hold their value after the handshake until the next operation captures byte 0.
- Request inputs are ignored outside IDLE. Changes to them after acceptance have no effect.
- ALU outputs are sampled in the same cycle they are driven. The block assumes a purely combinational ALU path.

## Test plan
- ADD 16'h00FF+16'h0001, cin 0 -> data 16'h0100, carry 0, zero 0, pari 1; resp_valid exactly 2 cycles after the acceptance edge.
- ADD 16'hFFFF+16'h0001 -> 16'h0000, carry 1, zero 1, pari 0. SUB 16'h1000-16'h0001 -> 16'h0FFF, carry 1, pari 0.
- CMP 16'h0001 vs 16'h0002 -> 16'h0000, zero 1, carry 0. CMP 16'h1234 vs 16'h1234 -> 16'h0001, carry 1.
- ROL 16'h8001, cin 1 -> 16'h0003, carry 1. REV 16'h1234 -> 16'h2C48. REV 16'h0001 -> 16'h8000.
- Back-to-back requests with resp_ready low 5 cycles: resp_valid and data hold, req_ready 0 throughout. Second request is accepted one cycle after the handshake.
- rst_n dropped mid-EXEC with an ADD in flight: all outputs 0 and ALU idle drive immediately. After release, a new AND 16'hF0F0&16'hFF00 -> 16'hF000, carry 0.
